processor_p: RTL and testbench
==============================

# processor_p

Parametrised successor to the 16-bit eight-register `processor` core. It keeps the same multi-cycle datapath: register file, IR, A and G registers, one shared bus and an adder. Data width and register count become parameters. The block adds a zero flag, logical AND, conditional move (`mvnz`), an asynchronous active-low reset on all state, and a defined `run`/`done` handshake. It is the CPU block a host/testbench drives word-by-word over `din`.

## Interface
- `DATA_W`, 16: datapath, bus, IR and register width. Must satisfy DATA_W ≥ 2·RW+3.
- `NREG`, 8: number of general registers R0..R(NREG-1). Power of two, ≥2. RW = clog2(NREG).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `din` input DATA_W: instruction word in IDLE; immediate word during `mvi` execute cycle.
- `run` input 1: instruction strobe, sampled only in IDLE.
- `done` output 1: high for exactly the final cycle of each instruction.
- `op` output DATA_W: debug view of the internal bus (combinational).
- `zflag` output 1: set when the last ALU result written to G was zero.

## Operation
- Instruction fields, with upper bits ignored:
  - opcode = IR[2·RW+2 : 2·RW]
  - Rx = IR[2·RW-1 : RW]
  - Ry = IR[RW-1 : 0]
- Opcodes:
  - 000 `mv` Rx←Ry
  - 001 `mvi` Rx←din
  - 010 `add` Rx←Rx+Ry
  - 011 `sub` Rx←Rx−Ry
  - 100 `and` Rx←Rx&Ry
  - 101 `mvnz` Rx←Ry if zflag==0
  - 110 and 111 are reserved: execute as NOP.
- FSM states IDLE, T1, T2, T3:
  - IDLE → T1 when `run`=1; IR←din on that edge. Otherwise stay in IDLE.
  - T1, `mv`: bus=Ry, write Rx, `done`=1 → IDLE.
  - T1, `mvi`: bus=din, write Rx, `done`=1 → IDLE.
  - T1, `mvnz`: bus=Ry, write Rx only if zflag==0; `done`=1 regardless → IDLE.
  - T1, NOP: no write, `done`=1 → IDLE.
  - T1, ALU ops: bus=Rx, A←bus → T2.
  - T2: bus=Ry, G←A op bus, zflag←(result==0) → T3.
  - T3: bus=G, write Rx, `done`=1 → IDLE.
- Bus source in IDLE is G.
- Arithmetic is modulo 2^DATA_W, with no carry/overflow output. `sub` is A + ~B + 1.
- zflag changes only in T2 of add/sub/and. `mv`, `mvi` and `mvnz` leave it unchanged.
- Rx==Ry is legal for every opcode (e.g. `sub R0,R0` → 0).
- `run` outside IDLE is ignored; it is neither queued nor latched.
- Reset asserted (low), at any time including mid-instruction:
  - state→IDLE; IR, A, G, all Rn → 0; zflag → 0.
  - The in-flight write is abandoned.
- Reset output values: `done`=0, `op`=0 (G), `zflag`=0.

## Timing
- Register/IR/A/G/zflag updates occur on the rising edge that ends the cycle asserting their enable.
- Latency from the `run` edge to `done`:
  - `mv`, `mvi`, `mvnz`, NOP: `done` in the next cycle (T1).
  - ALU ops: `done` in the third cycle (T3).
- Destination value is visible on `Rx` in the cycle after `done`.
- Back-to-back issue: `run` may be high in the cycle immediately after `done` (IDLE). Maximum throughput is one instruction per 2 or 4 cycles.
- `mvi` handshake: the host must hold the immediate on `din` during the T1 cycle, i.e. the cycle after `run`.
- `done` is a Moore decode of state plus IR opcode. It is glitch-free with respect to `din` and `run`.

## Structure
- Package `proc_p_pkg`:
  - opcode localparams OP_MV … OP_MVNZ.
  - state enum {IDLE,T1,T2,T3}.
  - ALU op enum {ALU_ADD, ALU_SUB, ALU_AND}.
  - field-extract functions parametrised on RW.
- Sub-module `proc_p_alu`:
  - parameters DATA_W; inputs A, B, alu_op.
  - outputs result and zero; combinational.
- Register file is an indexed array with a one-hot write enable from the FSM.
- Bus is a single parametrised mux: select among Rn, din, G.

## Test plan
Defaults DATA_W=16, NREG=8; opcode at IR[8:6].

1. Reset, then `run` with din=0x0040 and din=0x0005 in T1 → `done` in T1, `op`=0x0005; R0=0x0005; zflag=0.
2. R0=5, R1=0xFFFB; `add R1,R0` (0x0088) → `done` 3 cycles after `run`; R1=0x0000, zflag=1; `op`=0x0000 in T3.
3. After zflag=1, `mvnz R2,R0` (0x0150) → R2 unchanged (0). Then `sub R1,R0` gives R1=0xFFFB, zflag=0. Then repeat `mvnz` → R2=0x0005.
4. `and R3,R3` with R3=0 → zflag=1. Pulse `run` high during T1/T2 with another opcode → ignored; exactly one `done`.
5. Reset low during T2 of an `add` → immediately state IDLE, `done`=0, all registers 0. After release, no write occurs to Rx.
6. NREG=16, DATA_W=12: `mvi R15` (din=0x1F0 under the RW=4 encoding, opcode IR[10:8]=001, Rx=IR[7:4]=1111) then 0x0ABC → R15=0xABC. An `add` overflowing 0xFFF wraps modulo 2^12.

Source files
------------

// File: rtl/processor_p_pkg.sv
// Shared types, opcodes and instruction field extraction for the processor_p core.
package proc_p_pkg;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_MVNZ = 3'b101;

   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;
   typedef enum logic [1:0] {SRC_REG, SRC_DIN, SRC_G} bus_src_t;

   // Fields sit just above each other: opcode | Rx | Ry, each register field rw bits wide.
   function automatic logic [2:0] get_opcode(input logic [63:0] ir, input int unsigned rw);
      logic [63:0] sh;
      sh = ir >> (2 * rw);
      return sh[2:0];
   endfunction

   function automatic int unsigned get_rx(input logic [63:0] ir, input int unsigned rw);
      logic [63:0] sh;
      sh = (ir >> rw) & ((64'd1 << rw) - 64'd1);
      return sh[31:0];
   endfunction

   function automatic int unsigned get_ry(input logic [63:0] ir, input int unsigned rw);
      logic [63:0] sh;
      sh = ir & ((64'd1 << rw) - 64'd1);
      return sh[31:0];
   endfunction

   function automatic logic is_alu_op(input logic [2:0] opc);
      return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND);
   endfunction

endpackage

// File: rtl/processor_p_if.sv
// Host-side instruction/debug bus of processor_p.
interface processor_p_if #(parameter int DATA_W = 16);
   logic [DATA_W-1:0] din;
   logic              run;
   logic              done;
   logic [DATA_W-1:0] op;
   logic              zflag;

   modport master (output din, run, input done, op, zflag);
   modport slave  (input din, run, output done, op, zflag);
endinterface

// File: rtl/processor_p_alu.sv
// Combinational ALU: add, subtract (A + ~B + 1) and bitwise AND, with zero detect.
module proc_p_alu
   import proc_p_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  alu_op_t           alu_op_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);

   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   always_comb begin
      result_o = '0;
      case (alu_op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i + ~b_i + ONE;
         ALU_AND: result_o = a_i & b_i;
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/processor_p.sv
// Multi-cycle processor core: register file, IR, A/G registers, shared bus and ALU.
// state | meaning: IDLE wait for run | T1 decode/simple op | T2 ALU into G | T3 G into Rx
module processor_p
   import proc_p_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic          clk,
   input  logic          reset,
   processor_p_if.slave  bus_if
);

   localparam int unsigned RW = $clog2(NREG);

   state_t            state_q;
   logic [DATA_W-1:0] ir_q, a_q, g_q;
   logic [DATA_W-1:0] rf_q [NREG];
   logic              zflag_q, done_q;

   logic [2:0]        opcode, din_opcode;
   logic [RW-1:0]     rx, ry, bus_reg;
   bus_src_t          bus_src;
   logic [DATA_W-1:0] bus;
   logic [NREG-1:0]   wr_en;
   logic              a_en, g_en;
   alu_op_t           alu_op;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   assign opcode     = get_opcode(64'(ir_q), RW);
   assign din_opcode = get_opcode(64'(bus_if.din), RW);
   assign rx         = RW'(get_rx(64'(ir_q), RW));
   assign ry         = RW'(get_ry(64'(ir_q), RW));

   always_comb begin
      bus_src = SRC_G;
      bus_reg = ry;
      wr_en   = '0;
      a_en    = 1'b0;
      g_en    = 1'b0;
      case (state_q)
         T1: begin
            case (opcode)
               OP_MV:   begin bus_src = SRC_REG; wr_en[rx] = 1'b1; end
               OP_MVI:  begin bus_src = SRC_DIN; wr_en[rx] = 1'b1; end
               OP_MVNZ: begin bus_src = SRC_REG; wr_en[rx] = !zflag_q; end
               OP_ADD, OP_SUB, OP_AND: begin
                  bus_src = SRC_REG;
                  bus_reg = rx;
                  a_en    = 1'b1;
               end
               default: ;
            endcase
         end
         T2: begin
            bus_src = SRC_REG;
            g_en    = 1'b1;
         end
         T3: wr_en[rx] = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_SUB:  alu_op = ALU_SUB;
         OP_AND:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   end

   always_comb begin
      case (bus_src)
         SRC_REG: bus = rf_q[bus_reg];
         SRC_DIN: bus = bus_if.din;
         default: bus = g_q;
      endcase
   end

   proc_p_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (a_q),
      .b_i      (bus),
      .alu_op_i (alu_op),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         zflag_q <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wr_en[i]) rf_q[i] <= bus;
         end
         if (a_en) a_q <= bus;
         if (g_en) begin
            g_q     <= alu_result;
            zflag_q <= alu_zero;
         end
         // done is registered one state ahead so it depends only on state and IR
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus_if.run) begin
                  ir_q    <= bus_if.din;
                  state_q <= T1;
                  done_q  <= !is_alu_op(din_opcode);
               end
            end
            T1: state_q <= is_alu_op(opcode) ? T2 : IDLE;
            T2: begin
               state_q <= T3;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_if.op    = bus;
   assign bus_if.done  = done_q;
   assign bus_if.zflag = zflag_q;

endmodule

// File: tb/tb_processor_p.sv
// Scoreboard bench for processor_p: default 16-bit/8-reg core plus a 12-bit/16-reg instance.
module tb_processor_p;

   typedef struct {
      bit          chk;
      logic [15:0] op;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] mdl_r [8];
   bit          mdl_z;
   int          n_checks;
   int          n_errors;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   processor_p_if #(.DATA_W(16)) ifa ();
   processor_p_if #(.DATA_W(12)) ifb ();

   processor_p #(.DATA_W(16), .NREG(8))  dut_a (.clk(clk), .reset(reset), .bus_if(ifa));
   processor_p #(.DATA_W(12), .NREG(16)) dut_b (.clk(clk), .reset(reset), .bus_if(ifb));

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mdl_r[i] = 16'h0;
      mdl_z = 1'b0;
   endtask

   task automatic model_exec(input logic [15:0] instr, input logic [15:0] imm, output exp_t e);
      logic [2:0]  opc;
      int          rx, ry;
      logic [15:0] a, b, res;
      opc = instr[8:6];
      rx  = int'(instr[5:3]);
      ry  = int'(instr[2:0]);
      a   = mdl_r[rx];
      b   = mdl_r[ry];
      e.chk = 1'b1;
      e.lat = 1;
      e.op  = 16'h0;
      case (opc)
         3'b000: begin e.op = b; mdl_r[rx] = b; end
         3'b001: begin e.op = imm; mdl_r[rx] = imm; end
         3'b010, 3'b011, 3'b100: begin
            if (opc == 3'b010)      res = a + b;
            else if (opc == 3'b011) res = a - b;
            else                    res = a & b;
            e.op = res;
            e.lat = 3;
            mdl_r[rx] = res;
            mdl_z = (res == 16'h0);
         end
         3'b101: begin e.op = b; if (!mdl_z) mdl_r[rx] = b; end
         default: e.chk = 1'b0;
      endcase
   endtask

   // Called at a negedge with the core idle; returns at a negedge with the core idle again.
   task automatic issue(input logic [15:0] instr, input logic [15:0] imm);
      exp_t e, got;
      int   cyc;
      bit   seen;
      model_exec(instr, imm, e);
      sb_q.push_back(e);
      ifa.run = 1'b1;
      ifa.din = instr;
      @(posedge clk); #1;
      ifa.run = 1'b0;
      ifa.din = imm;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (ifa.done === 1'b1) begin
            seen = 1'b1;
            cyc  = i;
            break;
         end
      end
      got = sb_q.pop_front();
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL done_timeout instr=%h: got no done within 8 cycles, required done", instr);
      end else begin
         if (cyc !== got.lat) begin
            n_errors++;
            $display("FAIL latency instr=%h: got %0d cycles, required %0d", instr, cyc, got.lat);
         end
         if (got.chk) begin
            n_checks++;
            if (ifa.op !== got.op) begin
               n_errors++;
               $display("FAIL op_at_done instr=%h: got %h, required %h", instr, ifa.op, got.op);
            end
         end
      end
      @(negedge clk);
      n_checks++;
      if (ifa.zflag !== mdl_z) begin
         n_errors++;
         $display("FAIL zflag instr=%h: got %b, required %b", instr, ifa.zflag, mdl_z);
      end
      n_checks++;
      if (ifa.done !== 1'b0) begin
         n_errors++;
         $display("FAIL done_width instr=%h: got %b after done cycle, required 0", instr, ifa.done);
      end
   endtask

   task automatic read_reg(input int k);
      logic [15:0] instr;
      instr = 16'((k << 3) | k);
      issue(instr, 16'h0);
   endtask

   task automatic issue_b(input logic [11:0] instr, input logic [11:0] imm,
                          input logic [11:0] exp_op, input int exp_lat, input bit exp_z);
      exp_t e, got;
      int   cyc;
      e.chk = 1'b1;
      e.op  = {4'h0, exp_op};
      e.lat = exp_lat;
      sb_q.push_back(e);
      ifb.run = 1'b1;
      ifb.din = instr;
      @(posedge clk); #1;
      ifb.run = 1'b0;
      ifb.din = imm;
      cyc = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (ifb.done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      got = sb_q.pop_front();
      n_checks++;
      if (cyc !== got.lat) begin
         n_errors++;
         $display("FAIL wide_latency instr=%h: got %0d cycles, required %0d", instr, cyc, got.lat);
      end
      n_checks++;
      if (ifb.op !== got.op[11:0]) begin
         n_errors++;
         $display("FAIL wide_op instr=%h: got %h, required %h", instr, ifb.op, got.op[11:0]);
      end
      @(negedge clk);
      n_checks++;
      if (ifb.zflag !== exp_z) begin
         n_errors++;
         $display("FAIL wide_zflag instr=%h: got %b, required %b", instr, ifb.zflag, exp_z);
      end
   endtask

   task automatic test_reset();
      n_checks += 4;
      if (ifa.done !== 1'b0) begin
         n_errors++; $display("FAIL reset_done: got %b, required 0", ifa.done);
      end
      if (ifa.op !== 16'h0) begin
         n_errors++; $display("FAIL reset_op: got %h, required 0000", ifa.op);
      end
      if (ifa.zflag !== 1'b0) begin
         n_errors++; $display("FAIL reset_zflag: got %b, required 0", ifa.zflag);
      end
      if (ifb.op !== 12'h0) begin
         n_errors++; $display("FAIL reset_wide_op: got %h, required 000", ifb.op);
      end
   endtask

   task automatic test_mvi();
      issue(16'h0040, 16'h0005);
      read_reg(0);
   endtask

   task automatic test_add_zero();
      issue(16'h0048, 16'hFFFB);
      issue(16'h0088, 16'h0);
      read_reg(1);
   endtask

   task automatic test_mvnz();
      issue(16'h0150, 16'h0);
      read_reg(2);
      issue(16'h00C8, 16'h0);
      read_reg(1);
      issue(16'h0150, 16'h0);
      read_reg(2);
   endtask

   task automatic test_run_ignored();
      int n_done, first;
      ifa.run = 1'b1;
      ifa.din = 16'h011B;
      @(posedge clk); #1;
      ifa.din = 16'h0040;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ifa.run = 1'b0;
      n_done = 0;
      first  = 0;
      for (int i = 3; i <= 8; i++) begin
         @(negedge clk);
         if (ifa.done === 1'b1) begin
            n_done++;
            if (first == 0) first = i;
         end
      end
      mdl_z = 1'b1;
      n_checks += 3;
      if (n_done !== 1) begin
         n_errors++; $display("FAIL run_ignored_dones: got %0d, required 1", n_done);
      end
      if (first !== 3) begin
         n_errors++; $display("FAIL run_ignored_latency: got %0d, required 3", first);
      end
      if (ifa.zflag !== 1'b1) begin
         n_errors++; $display("FAIL and_zero_zflag: got %b, required 1", ifa.zflag);
      end
      read_reg(0);
      read_reg(3);
   endtask

   task automatic test_back_to_back();
      issue(16'h0060, 16'h1234);
      issue(16'h0068, 16'h0F0F);
      issue(16'h0125, 16'h0);
      issue(16'h00AC, 16'h0);
      issue(16'h00C0, 16'h0);
      issue(16'h0180, 16'h0);
      issue(16'h0035, 16'h0);
      for (int k = 0; k < 7; k++) read_reg(k);
   endtask

   task automatic test_reset_mid();
      ifa.run = 1'b1;
      ifa.din = 16'h0088;
      @(posedge clk); #1;
      ifa.run = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      n_checks += 3;
      if (ifa.done !== 1'b0) begin
         n_errors++; $display("FAIL midreset_done: got %b, required 0", ifa.done);
      end
      if (ifa.op !== 16'h0) begin
         n_errors++; $display("FAIL midreset_op: got %h, required 0000", ifa.op);
      end
      if (ifa.zflag !== 1'b0) begin
         n_errors++; $display("FAIL midreset_zflag: got %b, required 0", ifa.zflag);
      end
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (ifa.done !== 1'b0) begin
            n_errors++; $display("FAIL midreset_stray_done: got %b, required 0", ifa.done);
         end
      end
      for (int k = 0; k < 8; k++) read_reg(k);
   endtask

   task automatic test_wide();
      issue_b(12'h1F0, 12'hABC, 12'hABC, 1, 1'b0);
      issue_b(12'h0FF, 12'h000, 12'hABC, 1, 1'b0);
      issue_b(12'h110, 12'h001, 12'h001, 1, 1'b0);
      issue_b(12'h1E0, 12'hFFF, 12'hFFF, 1, 1'b0);
      issue_b(12'h2E1, 12'h000, 12'h000, 3, 1'b1);
      issue_b(12'h0EE, 12'h000, 12'h000, 1, 1'b1);
      issue_b(12'h2F1, 12'h000, 12'hABD, 3, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      ifa.run = 1'b0;
      ifa.din = 16'h0;
      ifb.run = 1'b0;
      ifb.din = 12'h0;
      reset = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b1;
      @(negedge clk);
      test_mvi();
      test_add_zero();
      test_mvnz();
      test_run_ignored();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
